// File: rtl/gpr_wb_arbiter_if.sv
// Write-back bus between the two GPR write requesters, the arbiter and the GPR write port.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready; ready never rises without valid.
interface gpr_wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          WE;
  logic [AW-1:0] RW;
  logic [DW-1:0] WD;
  logic          init_done;
  logic          grant_id;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, WE, RW, WD, init_done, grant_id
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, WE, RW, WD, init_done, grant_id
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Owns the GPR write port: clears registers 1..NUM_REG-1 after reset, then
// round-robins the port between two write-back requesters with zero-latency grants.
module gpr_wb_arbiter #(
  parameter int NUM_REG = 32,
  parameter int AW      = 5,
  parameter int DW      = 32
) (
  input  logic              clk,
  input  logic              reset,
  gpr_wb_arbiter_if.slave   bus,
  output logic              dbg_run
);
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [AW-1:0] CLR_LAST  = AW'(NUM_REG - 1);
  localparam logic [AW-1:0] CLR_FIRST = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          rr_last_q, rr_last_d;

  logic          grant_vld;
  logic          grant_sel;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // On contention the requester that did not win last time gets the port.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_sel = ~rr_last_q;
    end else if (bus.req0_valid) begin
      grant_vld = 1'b1;
      grant_sel = 1'b0;
    end else if (bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_sel = 1'b1;
    end
  end

  assign sel_addr = grant_sel ? bus.req1_addr : bus.req0_addr;
  assign sel_data = grant_sel ? bus.req1_data : bus.req0_data;

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    rr_last_d      = rr_last_q;
    bus.WE         = 1'b0;
    bus.RW         = '0;
    bus.WD         = '0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.init_done  = 1'b0;
    bus.grant_id   = 1'b0;
    // Outputs stay quiet for the whole time reset is held, not just at the edge.
    if (reset) begin
      case (state_q)
        ST_INIT: begin
          bus.WE = 1'b1;
          bus.RW = clr_cnt_q;
          if (clr_cnt_q == CLR_LAST) begin
            state_d   = ST_RUN;
            clr_cnt_d = CLR_FIRST;
          end else begin
            clr_cnt_d = clr_cnt_q + CLR_FIRST;
          end
        end
        ST_RUN: begin
          bus.init_done = 1'b1;
          if (grant_vld) begin
            bus.req0_ready = ~grant_sel;
            bus.req1_ready = grant_sel;
            bus.grant_id   = grant_sel;
            bus.RW         = sel_addr;
            bus.WD         = sel_data;
            // Writes to r0 are accepted and dropped so the requester never stalls.
            bus.WE         = (sel_addr != '0);
            rr_last_d      = grant_sel;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= CLR_FIRST;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign dbg_run = (state_q == ST_RUN);
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed reset/clear/arbitration scenarios plus a random
// phase; every cycle's write-port activity is scored against an expected queue.
module tb_gpr_wb_arbiter;
  localparam int NUM_REG = 32;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int EW      = 1 + AW + DW + 3;
  localparam logic [DW-1:0] G0_INIT = 32'h5A5A_0000;

  logic clk;
  logic reset;
  logic dbg_run;

  gpr_wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  gpr_wb_arbiter #(.NUM_REG(NUM_REG), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .dbg_run (dbg_run)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GPR stand-in: captures whatever the DUT writes.
  logic [DW-1:0] gpr [NUM_REG];
  always @(posedge clk) if (bus.WE) gpr[bus.RW] = bus.WD;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] exp_gpr [NUM_REG];
  int            n_vec;
  int            n_err;
  logic          rr;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  function automatic logic [EW-1:0] mk(input logic we, input logic [AW-1:0] rw,
                                       input logic [DW-1:0] wd, input logic gid,
                                       input logic r0, input logic r1);
    return {we, rw, wd, gid, r0, r1};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bus();
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
  endtask

  // Called just after a falling edge; samples mid-cycle, scores, advances to the next falling edge.
  task automatic run_cycle();
    logic [EW-1:0] obs;
    logic [EW-1:0] e;
    #2;
    obs = (bus.WE || bus.req0_ready || bus.req1_ready) ?
          mk(bus.WE, bus.RW, bus.WD, bus.grant_id, bus.req0_ready, bus.req1_ready) : '0;
    if (obs != '0 || exp_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check_val("sb_write", 64'(obs), 64'(e));
    end
    @(negedge clk);
  endtask

  // One RUN cycle with the current requester state; granted side drops its request.
  task automatic xact(output logic g);
    g = 1'b0;
    drive_bus();
    if (v0 || v1) begin
      g = (v0 && v1) ? ~rr : v1;
      if (g) begin
        exp_q.push_back(mk(a1 != '0, a1, d1, 1'b1, 1'b0, 1'b1));
        if (a1 != '0) exp_gpr[a1] = d1;
      end else begin
        exp_q.push_back(mk(a0 != '0, a0, d0, 1'b0, 1'b1, 1'b0));
        if (a0 != '0) exp_gpr[a0] = d0;
      end
      rr = g;
    end
    run_cycle();
    if (g) v1 = 1'b0;
    else   v0 = 1'b0;
    drive_bus();
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    #1;
    check_val("rst_forced", 64'({bus.WE, bus.RW, bus.WD, bus.req0_ready, bus.req1_ready,
                                 bus.init_done, bus.grant_id}), 64'(0));
    exp_q.delete();
    repeat (hold) @(negedge clk);
    reset = 1'b1;
    rr = 1'b1;
    for (int i = 1; i < NUM_REG; i++) begin
      exp_q.push_back(mk(1'b1, AW'(i), '0, 1'b0, 1'b0, 1'b0));
      exp_gpr[i] = '0;
    end
    for (int i = 0; i < NUM_REG - 1; i++) begin
      if (i == 0) begin
        #1;
        check_val("init_busy", 64'(bus.init_done), 64'(0));
        #1;
        run_cycle_tail();
      end else begin
        run_cycle();
      end
    end
    #1;
    check_val("init_done", 64'(bus.init_done), 64'(1));
    check_val("dbg_run", 64'(dbg_run), 64'(1));
    @(negedge clk);
  endtask

  // Same scoring as run_cycle when the mid-cycle delay was already spent.
  task automatic run_cycle_tail();
    logic [EW-1:0] obs;
    logic [EW-1:0] e;
    obs = (bus.WE || bus.req0_ready || bus.req1_ready) ?
          mk(bus.WE, bus.RW, bus.WD, bus.grant_id, bus.req0_ready, bus.req1_ready) : '0;
    if (obs != '0 || exp_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check_val("sb_write", 64'(obs), 64'(e));
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic g;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    a0 = '0;   a1 = '0;
    d0 = '0;   d1 = '0;
    drive_bus();
    gpr[0] = G0_INIT;
    for (int i = 1; i < NUM_REG; i++) gpr[i] = 32'hA5A5_0000 | DW'(i);
    for (int i = 0; i < NUM_REG; i++) exp_gpr[i] = '0;

    // Reset held 3 cycles, then the clear sequence.
    do_reset(3);
    for (int i = 1; i < NUM_REG; i++) check_val("clear_reg", 64'(gpr[i]), 64'(0));

    // Single requesters.
    v0 = 1'b1; a0 = AW'(10); d0 = 32'd100;
    xact(g);
    check_val("r10_after_req0", 64'(gpr[10]), 64'(100));
    v1 = 1'b1; a1 = AW'(20); d1 = 32'd200;
    xact(g);
    check_val("r20_after_req1", 64'(gpr[20]), 64'(200));

    // Contention: both continuously valid, grants must alternate 0,1,0,1.
    v0 = 1'b1; a0 = AW'(3); d0 = 32'h0300_0000 | $urandom_range(0, 255);
    v1 = 1'b1; a1 = AW'(4); d1 = 32'h0400_0000 | $urandom_range(0, 255);
    for (int i = 0; i < 4; i++) begin
      xact(g);
      check_val("contend_gid", 64'(g), 64'(i % 2));
      if (g) begin v1 = 1'b1; d1 = 32'h0400_0000 | $urandom_range(0, 255); end
      else   begin v0 = 1'b1; d0 = 32'h0300_0000 | $urandom_range(0, 255); end
    end
    v0 = 1'b0; v1 = 1'b0;
    drive_bus();
    check_val("r3_contend", 64'(gpr[3]), 64'(exp_gpr[3]));
    check_val("r4_contend", 64'(gpr[4]), 64'(exp_gpr[4]));

    // Zero register: accepted, not written.
    v1 = 1'b1; a1 = '0; d1 = 32'hDEAD_BEEF;
    xact(g);
    check_val("r0_untouched", 64'(gpr[0]), 64'(G0_INIT));

    // Idle: port quiet.
    drive_bus();
    #1;
    check_val("idle_port", 64'({bus.WE, bus.RW, bus.WD, bus.req0_ready, bus.req1_ready}), 64'(0));
    #1;
    run_cycle_tail();

    // Stall and hold: req0 wins, req1 holds addr 5 / data 55 and wins next.
    v0 = 1'b1; a0 = AW'(6); d0 = 32'd66;
    v1 = 1'b1; a1 = AW'(5); d1 = 32'd55;
    xact(g);
    check_val("stall_first_gid", 64'(g), 64'(0));
    xact(g);
    check_val("stall_second_gid", 64'(g), 64'(1));
    check_val("r5_held", 64'(gpr[5]), 64'(55));

    // Reset mid-RUN while req0 is offering a write.
    v0 = 1'b1; a0 = AW'(7); d0 = 32'd77;
    drive_bus();
    #2;
    check_val("pre_rst_ready", 64'(bus.req0_ready), 64'(1));
    do_reset(2);
    check_val("r10_recleared", 64'(gpr[10]), 64'(0));
    check_val("r20_recleared", 64'(gpr[20]), 64'(0));
    xact(g);
    check_val("r7_after_reset", 64'(gpr[7]), 64'(77));

    // Random phase: pending requests hold their addr/data until granted.
    for (int i = 0; i < 60; i++) begin
      if (!v0 && $urandom_range(0, 9) < 6) begin
        v0 = 1'b1; a0 = AW'($urandom_range(0, NUM_REG - 1)); d0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 9) < 6) begin
        v1 = 1'b1; a1 = AW'($urandom_range(0, NUM_REG - 1)); d1 = $urandom;
      end
      xact(g);
    end
    v0 = 1'b0; v1 = 1'b0;
    drive_bus();
    run_cycle();
    for (int i = 1; i < NUM_REG; i++) check_val("final_reg", 64'(gpr[i]), 64'(exp_gpr[i]));
    check_val("final_r0", 64'(gpr[0]), 64'(G0_INIT));

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Controller that owns the GPR single write port (WE/RW/WD).
- After reset it runs a clear sequence that writes 0 to registers 1..NUM_REG-1.
- It then shares the write port between two write-back requesters using round-robin arbitration and a valid/ready handshake.
- Sits between the datapath write-back sources (req0: main pipeline write-back, req1: multi-cycle unit / load return) and the GPR.

Parameters:
- NUM_REG, 32, number of GPR entries; register 0 is hard-wired zero.
- AW, 5, register address width; must satisfy 2^AW >= NUM_REG.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = asserted).
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  AW  requester 0 destination register.
- req0_data  in  DW  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  AW  requester 1 destination register.
- req1_data  in  DW  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle.
- WE  out  1  GPR write enable.
- RW  out  AW  GPR write address.
- WD  out  DW  GPR write data.
- init_done  out  1  clear sequence complete; port in service.
- grant_id  out  1  requester granted this cycle; valid only when a readyN=1.

Behaviour:
- Registered state: state {INIT, RUN}, clr_cnt[AW-1:0], rr_last (1 bit).
- Reset (reset=0, asynchronous): state=INIT, clr_cnt=1, rr_last=1.
- While reset=0, all outputs are forced combinationally: WE=0, RW=0, WD=0, req0_ready=req1_ready=0, init_done=0, grant_id=0.
- INIT, reset=1:
  - Outputs: WE=1, RW=clr_cnt, WD=0, both readies=0, init_done=0.
  - Each clk: clr_cnt<=clr_cnt+1.
  - When clr_cnt==NUM_REG-1: next state=RUN, clr_cnt<=1.
  - INIT lasts exactly NUM_REG-1 cycles (31 by default). Register 0 is never written.
- RUN: init_done=1. Grant rules are combinational in the same cycle:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester != rr_last.
  - Neither valid: no grant; WE=0, RW=0, WD=0, rr_last unchanged.
- On a grant g:
  - req{g}_ready=1 and the other ready=0.
  - RW=req{g}_addr, WD=req{g}_data, grant_id=g.
  - WE=1 unless req{g}_addr==0, in which case WE=0 but the request is still accepted (ready=1).
  - rr_last<=g at the clk edge.
- Transfer occurs when valid&&ready is high at a rising clk edge. The GPR captures the write on that same edge; write latency from grant is 0 cycles.
- Ready never asserts while valid=0. readyN depends on the valid inputs and state only, never on data.
- A requester must hold addr/data stable while valid=1 and ready=0.
- If both requesters target the same register in back-to-back grants, the later grant's data is the final value. No merging is performed.
- Reset asserted mid-INIT or mid-RUN: immediate return to the reset values. Any in-flight un-accepted request is not written. After release, the full clear sequence reruns.
- Throughput in RUN: one write per cycle. With both requesters continuously valid, grants strictly alternate.

Test Plan:
- Reset release: hold reset=0 for 3 cycles, then release -> WE=1 with RW=1..31 and WD=0 on consecutive cycles; init_done=1 on cycle 32; GPR reads 0 for all registers.
- Single requester: in RUN, req0 writes addr=10, data=100 -> req0_ready=1 the same cycle; GPR reads BusB=100 at RB=10 on the next cycle. Then req1 writes addr=20, data=200 -> BusA=200 at RA=20.
- Contention: req0 and req1 valid continuously for 4 cycles, req0 addr 3, req1 addr 4, distinct data -> grant_id sequence is 0,1,0,1 (rr_last=1 after reset); WE=1 every cycle.
- Zero register: req1 writes addr=0, data=0xDEADBEEF -> req1_ready=1, WE=0; register 0 still reads 0.
- Stall and hold: both valid with req0 granted -> req1_ready=0; req1 holds addr=5, data=55; on the next cycle req1 is granted and register 5 reads 55.
- Reset mid-operation: assert reset during RUN while req0 is valid -> WE=0 and readies=0 immediately; after release, INIT repeats for 31 cycles and previously written registers 10 and 20 read 0.
